sram_like_resp: RTL and testbench

SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

---
 rtl/sram_like_pkg.sv | 21 ++
 rtl/sram_like_ram.sv | 28 ++
 rtl/sram_like_resp.sv | 120 ++++++++++++
 tb/tb_sram_like_resp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like bus: transfer-size encodings, bus
// widths and the saturating age step used by the response queue.
package sram_like_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int AGE_W  = 4;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_e;

   // Advance an entry age by one cycle, holding at the completion latency.
   function automatic logic [AGE_W-1:0] age_step(input logic [AGE_W-1:0] age,
                                                 input logic [AGE_W-1:0] lim);
      return (age < lim) ? age + 1'b1 : lim;
   endfunction

endpackage

// File: rtl/sram_like_ram.sv
// Single-port word RAM with synchronous read and per-byte write enables.
// Contents are deliberately not reset.
module sram_like_ram
   import sram_like_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [MEM_AW-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

   // Byte-lane write and registered read of the addressed word.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like slave: accepts up to Q_DEPTH outstanding transactions, completes
// them strictly in order no earlier than RD_LAT cycles after acceptance.
module sram_like_resp
   import sram_like_pkg::*;
#(
   parameter int MEM_AW  = 10,
   parameter int Q_DEPTH = 4,
   parameter int RD_LAT  = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [3:0]        wstrb,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [DATA_W-1:0] rdata,
   input  logic              stall_addr,
   input  logic              stall_data
);

   localparam int PTR_W = $clog2(Q_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Q_DEPTH);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(RD_LAT);
   localparam logic [AGE_W-1:0] AGE_ACC  = AGE_W'(1);

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic              accept;
   logic              pop;
   logic [3:0]        ram_we;
   logic [DATA_W-1:0] ram_rdata;

   logic              cap_vld_p1;
   logic [PTR_W-1:0]  cap_slot_p1;

   logic              is_read_q [Q_DEPTH];
   logic [AGE_W-1:0]  age_q     [Q_DEPTH];
   logic [DATA_W-1:0] data_q    [Q_DEPTH];

   // Transfer size and sub-word address bits never change what is returned.
   logic unused_in;
   assign unused_in = ^{size, addr[ADDR_W-1:MEM_AW+2], addr[1:0]};

   assign addr_ok = resetn & ~stall_addr & (count < FULL_CNT);
   assign accept  = req & addr_ok;
   assign pop     = (count != '0) & (age_q[head] == AGE_MAX) & ~stall_data;
   assign data_ok = pop;
   assign rdata   = (pop & is_read_q[head]) ? data_q[head] : '0;
   assign ram_we  = (accept & wr) ? wstrb : 4'h0;

   sram_like_ram #(
      .MEM_AW (MEM_AW)
   ) u_ram (
      .clk   (clk),
      .en    (accept),
      .we    (ram_we),
      .addr  (addr[MEM_AW+1:2]),
      .wdata (wdata),
      .rdata (ram_rdata)
   );

   // Queue pointers and occupancy; simultaneous accept and pop cancel out.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (accept) tail <= tail + 1'b1;
         if (pop)    head <= head + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Per-entry type and age; the accept edge counts as the first cycle of age.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < Q_DEPTH; i++) begin
            is_read_q[i] <= 1'b0;
            age_q[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < Q_DEPTH; i++) begin
            if (accept && (PTR_W'(i) == tail)) begin
               is_read_q[i] <= ~wr;
               age_q[i]     <= AGE_ACC;
            end else begin
               age_q[i]     <= age_step(age_q[i], AGE_MAX);
            end
         end
      end
   end

   // Stage p1: remember which slot the in-flight RAM read belongs to.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cap_vld_p1  <= 1'b0;
         cap_slot_p1 <= '0;
      end else begin
         cap_vld_p1  <= accept & ~wr;
         cap_slot_p1 <= tail;
      end
   end

   // Stage p2: RAM output lands in its queue entry one cycle after accept.
   always_ff @(posedge clk) begin
      if (cap_vld_p1) data_q[cap_slot_p1] <= ram_rdata;
   end

endmodule

// File: tb/tb_sram_like_resp.sv
// Directed bench for sram_like_resp with a scoreboard of accepted
// transactions and a word-level memory model.
module tb_sram_like_resp;

   localparam int MEM_AW  = 10;
   localparam int Q_DEPTH = 4;
   localparam int RD_LAT  = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'd2;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall_addr = 1'b0;
   logic        stall_data = 1'b0;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   sram_like_resp #(
      .MEM_AW  (MEM_AW),
      .Q_DEPTH (Q_DEPTH),
      .RD_LAT  (RD_LAT)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (req),
      .wr         (wr),
      .size       (size),
      .wstrb      (wstrb),
      .addr       (addr),
      .wdata      (wdata),
      .addr_ok    (addr_ok),
      .data_ok    (data_ok),
      .rdata      (rdata),
      .stall_addr (stall_addr),
      .stall_data (stall_data)
   );

   typedef struct {
      logic        is_read;
      logic [31:0] data;
      int          acc_cyc;
   } ent_t;

   ent_t        sb[$];
   logic [31:0] mem_m [int];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_acc = 0;
   int          n_dok = 0;
   int          max_q = 0;
   logic        last_acc = 1'b0;
   logic [31:0] last_rd = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(a[MEM_AW+1:2]);
   endfunction

   // Cycle monitor: predicts handshake outputs, pops completions, pushes accepts.
   always @(negedge clk) begin
      ent_t        e;
      logic        exp_ok;
      logic        exp_pop;
      logic [31:0] w;
      cyc++;
      if (data_ok === 1'b1) n_dok++;
      if (!resetn) begin
         sb.delete();
         last_acc = 1'b0;
         chk("rst_addr_ok", {31'h0, addr_ok}, 32'h0);
         chk("rst_data_ok", {31'h0, data_ok}, 32'h0);
         chk("rst_rdata", rdata, 32'h0);
      end else begin
         exp_ok  = !stall_addr && (sb.size() < Q_DEPTH);
         exp_pop = (sb.size() != 0) && !stall_data && ((cyc - sb[0].acc_cyc) >= RD_LAT);
         chk("addr_ok", {31'h0, addr_ok}, {31'h0, exp_ok});
         chk("data_ok", {31'h0, data_ok}, {31'h0, exp_pop});
         if (exp_pop) begin
            e = sb.pop_front();
            chk(e.is_read ? "rdata_read" : "rdata_write", rdata, e.is_read ? e.data : 32'h0);
            if (e.is_read) last_rd = rdata;
         end else begin
            chk("rdata_idle", rdata, 32'h0);
         end
         last_acc = req && exp_ok;
         if (last_acc) begin
            n_acc++;
            w = mem_m.exists(widx(addr)) ? mem_m[widx(addr)] : 32'h0;
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
               mem_m[widx(addr)] = w;
            end
            e.is_read = !wr;
            e.data    = w;
            e.acc_cyc = cyc;
            sb.push_back(e);
            if (sb.size() > max_q) max_q = sb.size();
         end
      end
   end

   // Present one request and hold it until accepted (bounded).
   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int tries);
      logic acc;
      tries = 0;
      acc   = 1'b0;
      req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
      size = (s == 4'hf || !w) ? 2'd2 : 2'd0;
      while (!acc && tries < 50) begin
         @(negedge clk); #1;
         acc = last_acc;
         tries++;
         @(posedge clk); #1;
      end
      chk("send_accepted", {31'h0, acc}, 32'h1);
      req = 1'b0; wr = 1'b0; wstrb = 4'h0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      chk("drain_empty", sb.size(), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int tot;
      int n0;
      int idx;
      int d0;

      // Reset held for three cycles, then released just after an edge.
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk); #1;

      // Write then read the same word on consecutive cycles.
      req = 1'b1; wr = 1'b1; addr = 32'h1c000000; wdata = 32'hdeadbeef; wstrb = 4'hf;
      @(posedge clk); #1;
      wr = 1'b0; wstrb = 4'h0;
      @(posedge clk); #1;
      req = 1'b0;
      drain();
      chk("raw_rdata", last_rd, 32'hdeadbeef);

      // Byte-lane merge over an existing word.
      send(1'b1, 32'h1c000010, 32'h11223344, 4'hf, t);
      send(1'b1, 32'h1c000010, 32'h0000ab00, 4'b0010, t);
      send(1'b0, 32'h1c000010, 32'h0, 4'h0, t);
      drain();
      chk("byte_merge", last_rd, 32'h1122ab44);

      // Eight back-to-back reads with no back-pressure.
      for (int k = 0; k < 8; k++)
         send(1'b1, 32'h00000100 + 32'(4*k), 32'ha5a50000 + 32'(k*17), 4'hf, t);
      drain();
      max_q = 0;
      tot = 0;
      for (int k = 0; k < 8; k++) begin
         send(1'b0, 32'h00000100 + 32'(4*k), 32'h0, 4'h0, t);
         tot += t;
      end
      chk("burst_cycles", tot, 32'd8);
      drain();
      chk("burst_max_q_le3", {31'h0, (max_q <= 3)}, 32'h1);

      // Data-side stall fills the queue, then releases in order.
      n0 = n_acc;
      req = 1'b1; wr = 1'b0; addr = 32'h1c000000; stall_data = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("stall_accepts", n_acc - n0, 32'd4);
      stall_data = 1'b0;
      n0 = n_acc;
      repeat (4) @(posedge clk);
      #1;
      chk("resume_accepts", n_acc - n0, 32'd3);
      req = 1'b0;
      drain();

      // Reset with three reads outstanding.
      stall_data = 1'b1;
      send(1'b0, 32'h00000104, 32'h0, 4'h0, t);
      send(1'b0, 32'h00000108, 32'h0, 4'h0, t);
      send(1'b0, 32'h0000010c, 32'h0, 4'h0, t);
      resetn = 1'b0;
      stall_data = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      d0 = n_dok;
      repeat (6) @(posedge clk);
      #1;
      chk("no_dok_after_rst", n_dok - d0, 32'd0);
      send(1'b0, 32'h1c000000, 32'h0, 4'h0, t);
      drain();
      chk("mem_kept_after_rst", last_rd, 32'hdeadbeef);

      // Address-side stall toggling every cycle with req held.
      for (int k = 0; k < 6; k++)
         send(1'b1, 32'h00000200 + 32'(4*k), 32'h5a000000 ^ 32'(k*32'h01010101), 4'hf, t);
      drain();
      idx = 0;
      t = 0;
      req = 1'b1; wr = 1'b0;
      while (idx < 6 && t < 40) begin
         stall_addr = ~stall_addr;
         addr = 32'h00000200 + 32'(4*idx);
         @(negedge clk); #1;
         if (last_acc) idx++;
         t++;
         @(posedge clk); #1;
      end
      req = 1'b0; stall_addr = 1'b0;
      chk("toggle_reads_done", idx, 32'd6);
      drain();
      chk("toggle_last_rdata", last_rd, 32'h5a000000 ^ 32'(5*32'h01010101));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
